// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Runs one req/ack transaction per EX/MEM load or store. Loads are formatted
// for byte, half or word size with sign or zero extension. Stores get lane
// replication and byte enables. The pipeline is held on stall_o until the
// access completes.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   MemRead_i/MemWrite_i load/store request (write wins if both are set)
//   funct3_i             access size/sign
//   ALUResult_i          byte address
//   MemWdata_i           store data (rs2)
//   mem_req_o/mem_we_o   memory request / write strobe
//   mem_addr_o           word-aligned address
//   mem_wdata_o          lane-replicated store data
//   mem_be_o             byte enables (zero on reads)
//   mem_ack_i            one-cycle completion pulse
//   mem_rdata_i          read word, valid with mem_ack_i
//   Memdata_o            formatted load result (to MEM/WB)
//   stall_o              pipeline hold (combinational)
//   err_o                one-cycle pulse on illegal access or timeout
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] MemWdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] Memdata_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int unsigned CNT_W       = 8;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam bit          TO_EN       = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      memdata_q, memdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // access type and lane latched at request time for load formatting
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lane_q, lane_d;

  logic             access;
  logic             illegal;
  logic [31:0]      st_data;
  logic [3:0]       st_be;
  logic [31:0]      ld_data;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  assign access = MemRead_i | MemWrite_i;

  // Illegal: reserved funct3, store with the unsigned bit, misaligned word/half
  always_comb begin
    illegal = 1'b0;
    if (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111)
      illegal = 1'b1;
    if (MemWrite_i && funct3_i[2])
      illegal = 1'b1;
    if (funct3_i[1:0] == 2'b10 && ALUResult_i[1:0] != 2'b00)
      illegal = 1'b1;
    if (funct3_i[1:0] == 2'b01 && ALUResult_i[0])
      illegal = 1'b1;
  end

  // Store lane replication and byte enables
  always_comb begin
    st_data = MemWdata_i;
    st_be   = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        st_data = {4{MemWdata_i[7:0]}};
        st_be   = 4'b0001 << ALUResult_i[1:0];
      end
      2'b01: begin
        st_data = {2{MemWdata_i[15:0]}};
        st_be   = 4'b0011 << ALUResult_i[1:0];
      end
      default: begin
        st_data = MemWdata_i;
        st_be   = 4'b1111;
      end
    endcase
  end

  // Load lane selection and extension
  always_comb begin
    byte_sel = mem_rdata_i[7:0];
    case (lane_q)
      2'd0:    byte_sel = mem_rdata_i[7:0];
      2'd1:    byte_sel = mem_rdata_i[15:8];
      2'd2:    byte_sel = mem_rdata_i[23:16];
      default: byte_sel = mem_rdata_i[31:24];
    endcase
    half_sel = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ld_data  = mem_rdata_i;
    case (f3_q)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data = {24'h000000, byte_sel};
      3'b101:  ld_data = {16'h0000, half_sel};
      default: ld_data = mem_rdata_i;
    endcase
  end

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = TO_EN && (cnt_inc == TO_VAL);

  // State register and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      memdata_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      f3_q      <= '0;
      lane_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      memdata_q <= memdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      lane_q    <= lane_d;
    end
  end

  // Next-state and next-output logic; bus fields only change when leaving IDLE
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    memdata_d = memdata_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    lane_d    = lane_q;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (illegal) begin
            state_d   = ST_DONE;
            err_d     = 1'b1;
            memdata_d = '0;
          end else begin
            state_d = ST_WAIT;
            req_d   = 1'b1;
            we_d    = MemWrite_i;
            addr_d  = {ALUResult_i[31:2], 2'b00};
            wdata_d = st_data;
            be_d    = MemWrite_i ? st_be : 4'b0000;
            cnt_d   = '0;
            f3_d    = funct3_i;
            lane_d  = ALUResult_i[1:0];
          end
        end
      end
      ST_WAIT: begin
        // ack takes priority over a coincident timeout
        if (mem_ack_i) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (!we_q)
            memdata_d = ld_data;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            req_d     = 1'b0;
            err_d     = 1'b1;
            memdata_d = '0;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;
  assign Memdata_o   = memdata_q;
  assign err_o       = err_q;
  assign stall_o     = ((state_q == ST_IDLE) && access) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl, built with TIMEOUT=4.
module tb_mem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] ALUResult_i, MemWdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] Memdata_o;
  logic        stall_o, err_o;

  int checks = 0;
  int errors = 0;

  // results of the last run_access call
  int          r_stall, r_req;
  logic        r_err, r_err_after, r_done, r_stable, r_saw_req;
  logic [31:0] r_md, r_addr, r_wdata;
  logic        r_we;
  logic [3:0]  r_be;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .funct3_i    (funct3_i),
    .ALUResult_i (ALUResult_i),
    .MemWdata_i  (MemWdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .Memdata_o   (Memdata_o),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one access; ack in the ack_at-th WAIT cycle (0 = never). Returns in IDLE.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rdata);
    int wait_idx;
    wait_idx = 0;
    r_stall = 0; r_req = 0; r_err = 1'b0; r_err_after = 1'b0; r_done = 1'b0;
    r_stable = 1'b1; r_saw_req = 1'b0; r_md = '0;
    r_addr = '0; r_wdata = '0; r_we = 1'b0; r_be = '0;
    MemRead_i = rd; MemWrite_i = wr; funct3_i = f3; ALUResult_i = addr; MemWdata_i = wd;
    for (int c = 0; c < 40; c++) begin
      if (mem_req_o) begin
        wait_idx++;
        if (!r_saw_req) begin
          r_saw_req = 1'b1;
          r_addr = mem_addr_o; r_wdata = mem_wdata_o; r_we = mem_we_o; r_be = mem_be_o;
        end else if (mem_addr_o !== r_addr || mem_wdata_o !== r_wdata ||
                     mem_we_o !== r_we || mem_be_o !== r_be) begin
          r_stable = 1'b0;
        end
      end
      mem_ack_i   = mem_req_o && (wait_idx == ack_at);
      mem_rdata_i = rdata;
      #1;
      if (mem_req_o) r_req++;
      if (stall_o) begin
        r_stall++;
      end else begin
        r_done = 1'b1;
        r_err  = err_o;
        r_md   = Memdata_o;
        MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
        tick();
        r_err_after = err_o;
        break;
      end
      tick();
    end
    MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; funct3_i = 3'b000;
    ALUResult_i = '0; MemWdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mem_req_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", mem_we_o); end
    checks++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin errors++; $display("FAIL rst_bus got %h/%h exp 0/0", mem_addr_o, mem_wdata_o); end
    checks++; if (mem_be_o !== 4'h0) begin errors++; $display("FAIL rst_be got %b exp 0000", mem_be_o); end
    checks++; if (Memdata_o !== 32'h0) begin errors++; $display("FAIL rst_memdata got %h exp 0", Memdata_o); end
    checks++; if (err_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL rst_err_stall got %b/%b exp 0/0", err_o, stall_o); end
  endtask

  task automatic test_lw();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
    checks++; if (r_done !== 1'b1) begin errors++; $display("FAIL lw_done got %b exp 1", r_done); end
    checks++; if (r_stall !== 3) begin errors++; $display("FAIL lw_stall got %0d exp 3", r_stall); end
    checks++; if (r_req !== 2) begin errors++; $display("FAIL lw_req_cycles got %0d exp 2", r_req); end
    checks++; if (r_md !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", r_md); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", r_err); end
    checks++; if (r_addr !== 32'h100 || r_be !== 4'b0000 || r_we !== 1'b0) begin errors++; $display("FAIL lw_bus got %h/%b/%b exp 100/0000/0", r_addr, r_be, r_we); end
    checks++; if (r_stable !== 1'b1) begin errors++; $display("FAIL lw_stable got %b exp 1", r_stable); end
  endtask

  task automatic test_load_format();
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h80FF_7F01);
    checks++; if (r_md !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", r_md); end
    checks++; if (r_stall !== 2) begin errors++; $display("FAIL lb_stall got %0d exp 2", r_stall); end
    checks++; if (r_addr !== 32'h100) begin errors++; $display("FAIL lb_addr got %h exp 100", r_addr); end
    run_access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1, 32'h80FF_7F01);
    checks++; if (r_md !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", r_md); end
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 1, 32'h80FF_7F01);
    checks++; if (r_md !== 32'h0000_007F) begin errors++; $display("FAIL lb_lane1 got %h exp 0000007f", r_md); end
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h80FF_7F01);
    checks++; if (r_md !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_data got %h exp ffff80ff", r_md); end
    run_access(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 1, 32'h80FF_7F01);
    checks++; if (r_md !== 32'h0000_7F01) begin errors++; $display("FAIL lhu_data got %h exp 00007f01", r_md); end
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 1, 32'hFFFF_FFFF);
    checks++; if (r_addr !== 32'h200) begin errors++; $display("FAIL sh_addr got %h exp 200", r_addr); end
    checks++; if (r_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", r_be); end
    checks++; if (r_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcd", r_wdata); end
    checks++; if (r_we !== 1'b1) begin errors++; $display("FAIL sh_we got %b exp 1", r_we); end
    checks++; if (r_md !== 32'h0000_7F01) begin errors++; $display("FAIL sh_memdata_hold got %h exp 00007f01", r_md); end
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 1, 32'h0);
    checks++; if (r_be !== 4'b0010 || r_wdata !== 32'hA5A5_A5A5 || r_addr !== 32'h300) begin errors++; $display("FAIL sb_bus got %b/%h/%h exp 0010/a5a5a5a5/300", r_be, r_wdata, r_addr); end
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0404, 32'hCAFE_F00D, 1, 32'h0);
    checks++; if (r_be !== 4'b1111 || r_wdata !== 32'hCAFE_F00D || r_addr !== 32'h404) begin errors++; $display("FAIL sw_bus got %b/%h/%h exp 1111/cafef00d/404", r_be, r_wdata, r_addr); end
    // both strobes set: treated as a store
    run_access(1'b1, 1'b1, 3'b000, 32'h0000_0302, 32'h0000_0077, 1, 32'h1111_1111);
    checks++; if (r_we !== 1'b1 || r_be !== 4'b0100 || r_wdata !== 32'h7777_7777) begin errors++; $display("FAIL rdwr_bus got %b/%b/%h exp 1/0100/77777777", r_we, r_be, r_wdata); end
    checks++; if (r_md !== 32'h0000_7F01) begin errors++; $display("FAIL rdwr_memdata got %h exp 00007f01", r_md); end
  endtask

  task automatic test_illegal();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 1, 32'h1234_5678);
    checks++; if (r_saw_req !== 1'b0) begin errors++; $display("FAIL misal_req got %b exp 0", r_saw_req); end
    checks++; if (r_stall !== 1) begin errors++; $display("FAIL misal_stall got %0d exp 1", r_stall); end
    checks++; if (r_err !== 1'b1 || r_err_after !== 1'b0) begin errors++; $display("FAIL misal_err_pulse got %b%b exp 10", r_err, r_err_after); end
    checks++; if (r_md !== 32'h0) begin errors++; $display("FAIL misal_memdata got %h exp 0", r_md); end
    run_access(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 1, 32'h1234_5678);
    checks++; if (r_saw_req !== 1'b0 || r_stall !== 1 || r_err !== 1'b1) begin errors++; $display("FAIL f3_011 got req%b stall%0d err%b exp req0 stall1 err1", r_saw_req, r_stall, r_err); end
    run_access(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 1, 32'h0);
    checks++; if (r_saw_req !== 1'b0 || r_err !== 1'b1) begin errors++; $display("FAIL st_unsigned got req%b err%b exp req0 err1", r_saw_req, r_err); end
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0, 1, 32'h0);
    checks++; if (r_saw_req !== 1'b0 || r_err !== 1'b1) begin errors++; $display("FAIL lh_misal got req%b err%b exp req0 err1", r_saw_req, r_err); end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 4, 32'h1122_3344);
    checks++; if (r_req !== 4 || r_stall !== 5) begin errors++; $display("FAIL ack_at_limit_cycles got req%0d stall%0d exp req4 stall5", r_req, r_stall); end
    checks++; if (r_err !== 1'b0 || r_md !== 32'h1122_3344) begin errors++; $display("FAIL ack_at_limit got err%b data %h exp err0 data 11223344", r_err, r_md); end
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 0, 32'h5555_5555);
    checks++; if (r_done !== 1'b1) begin errors++; $display("FAIL to_done got %b exp 1", r_done); end
    checks++; if (r_req !== 4 || r_stall !== 5) begin errors++; $display("FAIL to_cycles got req%0d stall%0d exp req4 stall5", r_req, r_stall); end
    checks++; if (r_err !== 1'b1 || r_err_after !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %b%b exp 10", r_err, r_err_after); end
    checks++; if (r_md !== 32'h0) begin errors++; $display("FAIL to_memdata got %h exp 0", r_md); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0, 1, 32'hA5A5_5A5A);
    checks++; if (r_md !== 32'hA5A5_5A5A || r_stall !== 2) begin errors++; $display("FAIL b2b_first got %h stall%0d exp a5a55a5a stall2", r_md, r_stall); end
    run_access(1'b1, 1'b0, 3'b100, 32'h0000_0701, 32'h0, 1, 32'h0000_C300);
    checks++; if (r_md !== 32'h0000_00C3 || r_stall !== 2) begin errors++; $display("FAIL b2b_second got %h stall%0d exp 000000c3 stall2", r_md, r_stall); end
  endtask

  task automatic test_reset_in_wait();
    MemRead_i = 1'b1; funct3_i = 3'b010; ALUResult_i = 32'h0000_0600;
    tick();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rw_req_up got %b exp 1", mem_req_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; MemRead_i = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL rw_after_rst got req%b stall%b exp req0 stall0", mem_req_o, stall_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    mem_ack_i = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0 || err_o !== 1'b0 || Memdata_o !== 32'h0 || stall_o !== 1'b0) begin errors++; $display("FAIL rw_stray_ack got req%b err%b data %h stall%b exp 0 0 0 0", mem_req_o, err_o, Memdata_o, stall_o); end
    tick();
    checks++; if (err_o !== 1'b0 || Memdata_o !== 32'h0) begin errors++; $display("FAIL rw_stray_ack_late got err%b data %h exp 0 0", err_o, Memdata_o); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_format();
    test_store();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
